// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Measures the rise-to-rise period of mon_clk in clk_in cycles. mon_clk is
//   treated as data: it is synchronised, edge-detected and counted on clk_in.
//
// Ports
//   clk_in       in   single clock, posedge
//   rst          in   synchronous active-high reset
//   mon_clk      in   signal under measurement (never used as a clock)
//   start        in   one-cycle request to measure; only honoured in IDLE
//   cont         in   keep re-measuring after each result
//   period       out  last measured period, held until the next result
//   period_valid out  one-cycle pulse when period updates
//   busy         out  high while arming or measuring
//   timeout      out  one-cycle pulse when no rise arrived within TIMEOUT cycles
//   mismatch     out  one-cycle pulse alongside period_valid when out of tolerance
//
// Build option: PERIOD_CHECK_EN enables the EXP_PERIOD +/- TOL comparator;
// without it mismatch is constant 0.

module clk_period_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned EXP_PERIOD  = 4,
  parameter int unsigned TOL         = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             busy,
  output logic             timeout,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (64'(TIMEOUT) >= (64'd1 << CNT_W) ||
      64'(EXP_PERIOD) >= (64'd1 << CNT_W) ||
      64'(TOL) >= (64'd1 << CNT_W)) begin : g_bad_range
    $error("TIMEOUT, EXP_PERIOD and TOL must fit in CNT_W bits");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_period;
  logic             timeout_nx;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A rise takes priority over the timeout check in both waiting states.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    load_period = 1'b0;
    timeout_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARM;
          cnt_nx   = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_nx = MEASURE;
          cnt_nx   = CNT_ONE;
        end else if (cnt == TIMEOUT_C) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          load_period = 1'b1;
          cnt_nx      = CNT_ONE;
          state_nx    = cont ? MEASURE : IDLE;
        end else if (cnt == TIMEOUT_C) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      period_valid <= load_period;
      timeout      <= timeout_nx;
      if (load_period) begin
        period <= cnt;
      end
    end
  end

`ifdef PERIOD_CHECK_EN
  // One extra bit so the absolute difference never wraps.
  logic [CNT_W:0] meas_x;
  logic [CNT_W:0] exp_x;
  logic [CNT_W:0] diff;

  assign meas_x = {1'b0, cnt};
  assign exp_x  = (CNT_W+1)'(EXP_PERIOD);
  assign diff   = (meas_x >= exp_x) ? (meas_x - exp_x) : (exp_x - meas_x);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= load_period && (diff > (CNT_W+1)'(TOL));
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
module tb_clk_period_monitor;

  typedef struct packed {
    logic        is_to;
    logic [15:0] period;
    logic        mm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic cont_a = 1'b0;
  logic cont_b = 1'b0;

  logic [15:0] a_period, b_period;
  logic a_pv, a_busy, a_to, a_mm;
  logic b_pv, b_busy, b_to, b_mm;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int a_seen = 0, b_seen = 0;
  int a_to_cyc = -1;

  int gen_p = 4;
  bit gen_en = 1'b0;
  int ph = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_period_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut_a (
    .clk_in(clk), .rst(rst), .mon_clk(mon), .start(start_a), .cont(cont_a),
    .period(a_period), .period_valid(a_pv), .busy(a_busy),
    .timeout(a_to), .mismatch(a_mm)
  );

  clk_period_monitor #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(8)) dut_b (
    .clk_in(clk), .rst(rst), .mon_clk(mon), .start(start_b), .cont(cont_b),
    .period(b_period), .period_valid(b_pv), .busy(b_busy),
    .timeout(b_to), .mismatch(b_mm)
  );

  // mon_clk source: a divide-by-gen_p waveform, high for the first half.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_en) begin
        ph  = (ph + 1) % gen_p;
        mon = (ph < gen_p / 2);
      end else begin
        mon = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected mismatch for the default EXP_PERIOD=4, TOL=0.
  function automatic bit exp_mm(input int p);
`ifdef PERIOD_CHECK_EN
    return ((p > 4) ? (p - 4) : (4 - p)) > 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk(input bit is_to, input int p, input bit mm);
    exp_t e;
    e.is_to  = is_to;
    e.period = 16'(p);
    e.mm     = mm;
    return e;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_pv || a_to || a_mm) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected: pv=%0b to=%0b mm=%0b period=%0d, expected no pulse (cycle %0d)",
                 a_pv, a_to, a_mm, a_period, cyc);
      end else begin
        e = qa.pop_front();
        check("a_kind", {30'd0, a_pv, a_to}, {30'd0, ~e.is_to, e.is_to});
        check("a_period", a_period, e.period);
        check("a_mismatch", a_mm, e.mm);
      end
      a_seen++;
      if (a_to) a_to_cyc = cyc;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_pv || b_to || b_mm) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected: pv=%0b to=%0b mm=%0b period=%0d, expected no pulse (cycle %0d)",
                 b_pv, b_to, b_mm, b_period, cyc);
      end else begin
        e = qb.pop_front();
        check("b_kind", {30'd0, b_pv, b_to}, {30'd0, ~e.is_to, e.is_to});
        check("b_period", b_period, e.period);
        check("b_mismatch", b_mm, e.mm);
      end
      b_seen++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_seen_a(input int target, input int budget);
    int g = 0;
    while (a_seen < target && g < budget) begin
      tick(1);
      g++;
    end
    check("a_result_arrived", a_seen >= target, 1);
  endtask

  task automatic wait_idle_a(input int budget);
    int g = 0;
    while (a_busy && g < budget) begin
      tick(1);
      g++;
    end
    check("a_busy_drops", a_busy, 0);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    #1;
  endtask

  initial begin
    int t0;
    // Reset state
    tick(3);
    check("rst_period", a_period, 0);
    check("rst_pv", a_pv, 0);
    check("rst_busy", a_busy, 0);
    check("rst_timeout", a_to, 0);
    check("rst_mismatch", a_mm, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Divide-by-4, single shot
    gen_p = 4; ph = 0; gen_en = 1'b1;
    tick(6);
    qa.push_back(mk(1'b0, 4, exp_mm(4)));
    pulse_start_a();
    check("t1_busy_after_start", a_busy, 1);
    wait_seen_a(1, 40);
    wait_idle_a(10);
    tick(8);
    check("t1_period_held", a_period, 4);

    // Start re-issued while busy must not restart the count
    qa.push_back(mk(1'b0, 4, exp_mm(4)));
    pulse_start_a();
    for (int i = 0; i < 3; i++) begin
      start_a = 1'b1;
      check("t5_busy_during_restart", a_busy, 1);
      tick(1);
    end
    start_a = 1'b0;
    wait_seen_a(2, 40);
    wait_idle_a(10);
    tick(10);
    check("t5_single_result", a_seen, 2);

    // Reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    #1;
    check("rst_start_busy", a_busy, 0);
    check("rst_start_period", a_period, 0);
    tick(3);
    check("rst_start_still_idle", a_busy, 0);

    // Divide-by-2, continuous mode: six results, cont dropped after the fifth
    gen_p = 2; ph = 0;
    tick(4);
    for (int i = 0; i < 6; i++) qa.push_back(mk(1'b0, 2, exp_mm(2)));
    cont_a = 1'b1;
    pulse_start_a();
    wait_seen_a(7, 60);
    cont_a = 1'b0;
    wait_seen_a(8, 20);
    wait_idle_a(10);
    tick(6);
    check("t2_result_count", a_seen, 8);

    // mon_clk stuck low: timeout after the ARM count reaches 20
    gen_en = 1'b0;
    tick(6);
    qa.push_back(mk(1'b1, 2, 1'b0));
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t0 = cyc;
    #1;
    wait_seen_a(9, 40);
    // cnt counts 0..20 over 20 cycles in ARM; the pulse is registered on the next edge.
    check("t3_timeout_latency", a_to_cyc - t0, 21);
    check("t3_idle_after_timeout", a_busy, 0);
    check("t3_period_kept", a_period, 2);

    // Reset mid-measurement in continuous mode aborts without further pulses
    gen_p = 4; ph = 0; gen_en = 1'b1;
    tick(6);
    qa.push_back(mk(1'b0, 4, exp_mm(4)));
    cont_a = 1'b1;
    pulse_start_a();
    wait_seen_a(10, 40);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t4_period_cleared", a_period, 0);
    check("t4_busy_cleared", a_busy, 0);
    check("t4_pv_cleared", a_pv, 0);
    check("t4_timeout_cleared", a_to, 0);
    rst = 1'b0;
    tick(40);
    check("t4_no_pulses_after_abort", a_seen, 10);
    check("t4_stays_idle", a_busy, 0);
    cont_a = 1'b0;

    // Period 8 against TIMEOUT 8: the rise coincides with the limit and wins
    gen_p = 8; ph = 0;
    tick(10);
    qb.push_back(mk(1'b0, 8, exp_mm(8)));
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    #1;
    check("t6_busy", b_busy, 1);
    begin
      int g = 0;
      while (b_busy && g < 60) begin
        tick(1);
        g++;
      end
    end
    check("t6_busy_drops", b_busy, 0);
    tick(10);
    check("t6_result_count", b_seen, 1);
    check("t6_period", b_period, 8);

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
